aes_link_sequencer: RTL and testbench



---
 rtl/aes_link_pkg.sv | 19 +
 rtl/link_gap_timer.sv | 32 +++
 rtl/aes_link_sequencer.sv | 148 ++++++++++++++
 tb/tb_aes_link_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_link_pkg.sv
// Shared definitions for the UART <-> AES link sequencer.
//   BLOCK_BITS   : width of one AES block / serial frame
//   link_state_t : sequencer state encoding
package aes_link_pkg;

   localparam int BLOCK_BITS = 128;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RX     = 3'd1,
      ST_START  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_GAP_TX = 3'd4,
      ST_TX     = 3'd5,
      ST_GAP_RX = 3'd6,
      ST_ERR    = 3'd7
   } link_state_t;

endpackage

// File: rtl/link_gap_timer.sv
// Loadable down-counter with terminal-count flag.
//   Clk, Rst_n : clock, async active-low reset
//   load       : load load_val (has priority over en)
//   load_val   : value to load
//   en         : decrement by one per cycle, saturating at zero
//   done       : count is zero
module link_gap_timer #(
   parameter int W = 4
) (
   input  logic         Clk,
   input  logic         Rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/aes_link_sequencer.sv
// Sequencer pairing the serial block with the AES core: receive one block,
// run AES on it, transmit the result, optionally repeat.
//   Clk, Rst_n       : clock, async active-low reset
//   Run              : keep processing blocks while high
//   Mode             : 0 encrypt / 1 decrypt, captured with the block
//   ReadRy, PT       : received block strobe and data
//   WriteRy          : transmitter finished sending Result
//   ReadEn, WriteEn  : serial receive / transmit enables
//   Result           : AES output held for the transmitter
//   AesStart, AesMode, AesIn, AesOut, AesDone : AES core handshake
//   Busy, Error, BlkCount : status
//
// state   | meaning
// IDLE    | quiet, waiting for Run
// RX      | ReadEn high, waiting for a full block
// START   | one-cycle AesStart pulse, arm timeout
// WAIT    | waiting for AesDone, timeout running
// GAP_TX  | enables low while Result settles
// TX      | WriteEn high, waiting for WriteRy
// GAP_RX  | enables low so the serial block clears its counters
// ERR     | AES timed out; Run=0 returns to IDLE
module aes_link_sequencer
   import aes_link_pkg::*;
#(
   parameter int AES_TIMEOUT = 1024,
   parameter int TO_W        = 11,
   parameter int GAP_CYCLES  = 4,
   parameter int BLK_W       = 16
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  Run,
   input  logic                  Mode,
   input  logic                  ReadRy,
   input  logic [BLOCK_BITS-1:0] PT,
   input  logic                  WriteRy,
   output logic                  ReadEn,
   output logic                  WriteEn,
   output logic [BLOCK_BITS-1:0] Result,
   output logic                  AesStart,
   output logic                  AesMode,
   output logic [BLOCK_BITS-1:0] AesIn,
   input  logic [BLOCK_BITS-1:0] AesOut,
   input  logic                  AesDone,
   output logic                  Busy,
   output logic                  Error,
   output logic [BLK_W-1:0]      BlkCount
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   link_state_t state, state_nxt;
   logic        gap_load, gap_done;
   logic        to_load, to_done;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      gap_load  = 1'b0;
      to_load   = 1'b0;
      case (state)
         ST_IDLE:   if (Run) state_nxt = ST_RX;
         // A completed block is still processed even if Run fell with it.
         ST_RX: begin
            if (ReadRy)    state_nxt = ST_START;
            else if (!Run) state_nxt = ST_IDLE;
         end
         ST_START: begin
            to_load   = 1'b1;
            state_nxt = ST_WAIT;
         end
         // AesDone beats a coincident terminal count.
         ST_WAIT: begin
            if (AesDone) begin
               gap_load  = 1'b1;
               state_nxt = ST_GAP_TX;
            end else if (to_done) begin
               state_nxt = ST_ERR;
            end
         end
         ST_GAP_TX: if (gap_done) state_nxt = ST_TX;
         ST_TX: begin
            if (WriteRy) begin
               gap_load  = 1'b1;
               state_nxt = ST_GAP_RX;
            end
         end
         ST_GAP_RX: if (gap_done) state_nxt = Run ? ST_RX : ST_IDLE;
         ST_ERR:    if (!Run) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Gap timer is loaded on entry, so each gap state lasts GAP_CYCLES cycles.
   link_gap_timer #(.W(GAP_W)) u_gap_timer (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .load     (gap_load),
      .load_val (GAP_W'(GAP_CYCLES - 1)),
      .en       ((state == ST_GAP_TX) || (state == ST_GAP_RX)),
      .done     (gap_done)
   );

   // The START cycle counts toward the timeout, so the error lands exactly
   // AES_TIMEOUT cycles after AesStart rises.
   link_gap_timer #(.W(TO_W)) u_to_timer (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .load     (to_load),
      .load_val (TO_W'(AES_TIMEOUT - 2)),
      .en       (state == ST_WAIT),
      .done     (to_done)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         AesIn    <= '0;
         AesMode  <= 1'b0;
         Result   <= '0;
         Error    <= 1'b0;
         BlkCount <= '0;
      end else begin
         if ((state == ST_RX) && ReadRy) begin
            AesIn   <= PT;
            AesMode <= Mode;
         end
         if ((state == ST_WAIT) && AesDone) begin
            Result <= AesOut;
         end
         if ((state == ST_WAIT) && !AesDone && to_done) begin
            Error <= 1'b1;
         end
         if ((state == ST_TX) && WriteRy) begin
            BlkCount <= BlkCount + BLK_W'(1);
         end
      end
   end

   assign ReadEn   = (state == ST_RX);
   assign WriteEn  = (state == ST_TX);
   assign AesStart = (state == ST_START);
   assign Busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_aes_link_sequencer.sv
module tb_aes_link_sequencer;

   logic         Clk = 1'b0, Rst_n = 1'b0, Run = 1'b0, Mode = 1'b0;
   logic         ReadRy = 1'b0, WriteRy = 1'b0, AesDone = 1'b0;
   logic [127:0] PT = '0, AesOut = '0;
   logic         ReadEn, WriteEn, AesStart, AesMode, Busy, Error;
   logic [127:0] Result, AesIn;
   logic [15:0]  BlkCount;

   int tests = 0;
   int fails = 0;

   logic [128:0] start_q[$];
   logic [127:0] tx_q[$];
   logic [15:0]  blk_q[$];
   logic [15:0]  blk_model = '0;
   logic [128:0] exp_start;
   logic [127:0] exp_tx;
   logic [15:0]  exp_blk;
   logic         wr_prev = 1'b0;

   always #5 Clk = ~Clk;

   aes_link_sequencer dut (
      .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Mode(Mode), .ReadRy(ReadRy), .PT(PT),
      .WriteRy(WriteRy), .ReadEn(ReadEn), .WriteEn(WriteEn), .Result(Result),
      .AesStart(AesStart), .AesMode(AesMode), .AesIn(AesIn), .AesOut(AesOut),
      .AesDone(AesDone), .Busy(Busy), .Error(Error), .BlkCount(BlkCount)
   );

   task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Monitor: pops expectations whenever the DUT presents a start, a
   // transmit frame, or completes a transmit.
   always @(negedge Clk) begin
      if (ReadEn || WriteEn) check("enables_exclusive", {ReadEn, WriteEn} == 2'b11, 0);
      if (AesStart) begin
         if (start_q.size() == 0) begin
            check("start_unexpected", 1, 0);
         end else begin
            exp_start = start_q.pop_front();
            check("aes_in_mode", {AesMode, AesIn}, exp_start);
         end
      end
      if (WriteEn && !wr_prev) begin
         if (tx_q.size() == 0) begin
            check("tx_unexpected", 1, 0);
         end else begin
            exp_tx = tx_q.pop_front();
            check("result", Result, exp_tx);
         end
      end
      if (!WriteEn && wr_prev) begin
         if (blk_q.size() == 0) begin
            check("blk_unexpected", 1, 0);
         end else begin
            exp_blk = blk_q.pop_front();
            check("blk_count", BlkCount, exp_blk);
         end
      end
      wr_prev = WriteEn;
   end

   task automatic run_block(input logic [127:0] pt, input logic mode, input logic [127:0] aout,
                            input int aes_lat, input int wr_lat, input bit spur, input bit drop);
      int n;
      Run = 1'b1;
      n = 0;
      while (!ReadEn && n < 50) begin tick(); n++; end
      check("rx_enable", ReadEn, 1);
      if (spur) begin
         WriteRy = 1'b1;
         tick();
         WriteRy = 1'b0;
         check("spur_wr_state", ReadEn, 1);
         check("spur_wr_blk", BlkCount, blk_model);
      end
      PT = pt; Mode = mode; ReadRy = 1'b1;
      start_q.push_back({mode, pt});
      tick();
      ReadRy = 1'b0;
      Mode = ~mode;
      PT = ~pt;
      check("start_latency", AesStart, 1);
      tick();
      check("start_width", AesStart, 0);
      if (spur) begin
         ReadRy = 1'b1;
         tick();
         ReadRy = 1'b0;
         check("spur_rd_aes_in", {AesMode, AesIn}, {mode, pt});
         check("spur_rd_state", ReadEn, 0);
      end
      repeat (aes_lat) tick();
      AesOut = aout; AesDone = 1'b1;
      tx_q.push_back(aout);
      tick();
      AesDone = 1'b0;
      AesOut = {$urandom, $urandom, $urandom, $urandom};
      n = 1;
      while (!WriteEn && n < 30) begin tick(); n++; end
      check("tx_latency", n, 5);
      if (drop) Run = 1'b0;
      repeat (wr_lat) tick();
      WriteRy = 1'b1;
      blk_model = blk_model + 16'd1;
      blk_q.push_back(blk_model);
      tick();
      WriteRy = 1'b0;
      if (!drop) begin
         n = 1;
         while (!ReadEn && n < 30) begin tick(); n++; end
         check("rx_gap_latency", n, 5);
      end else begin
         repeat (8) tick();
         check("drop_read_en", ReadEn, 0);
         check("drop_busy", Busy, 0);
      end
   endtask

   initial begin
      int n;
      // Reset state
      #3;
      check("rst_outputs", {ReadEn, WriteEn, AesStart, AesMode, Busy, Error}, 0);
      check("rst_data", {Result, AesIn, BlkCount} == 0, 1);
      #20 Rst_n = 1'b1;
      tick();
      check("idle_busy", Busy, 0);

      // Known-answer block
      run_block(128'h00112233445566778899aabbccddeeff, 1'b0,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 3, 2, 1'b0, 1'b0);
      check("blk_after_first", BlkCount, 16'd1);

      // Spurious handshakes
      run_block({$urandom, $urandom, $urandom, $urandom}, 1'b1,
                {$urandom, $urandom, $urandom, $urandom}, 2, 1, 1'b1, 1'b0);

      // Random blocks
      for (int i = 0; i < 16; i++) begin
         run_block({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                   {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 25),
                   $urandom_range(0, 6), ($urandom_range(0, 3) == 0), 1'b0);
      end

      // Run dropped during TX
      run_block({$urandom, $urandom, $urandom, $urandom}, 1'b1,
                {$urandom, $urandom, $urandom, $urandom}, 5, 3, 1'b0, 1'b1);

      // Counter wrap
      force dut.BlkCount = 16'hFFFF;
      tick();
      release dut.BlkCount;
      blk_model = 16'hFFFF;
      tick();
      run_block({$urandom, $urandom, $urandom, $urandom}, 1'b0,
                {$urandom, $urandom, $urandom, $urandom}, 1, 0, 1'b0, 1'b0);
      check("blk_wrap", BlkCount, 16'h0000);

      // AES timeout
      n = 0;
      while (!ReadEn && n < 50) begin tick(); n++; end
      PT = 128'hdeadbeef; Mode = 1'b1; ReadRy = 1'b1;
      start_q.push_back({1'b1, 128'hdeadbeef});
      tick();
      ReadRy = 1'b0;
      check("to_start", AesStart, 1);
      n = 0;
      while (!Error && n < 1100) begin tick(); n++; end
      check("timeout_cycles", n, 1024);
      repeat (3) tick();
      check("err_enables", {ReadEn, WriteEn, AesStart}, 0);
      check("err_busy", Busy, 1);
      AesDone = 1'b1;
      tick();
      AesDone = 1'b0;
      check("err_ignores_done", {Busy, WriteEn}, 2'b10);
      Run = 1'b0;
      tick();
      check("err_to_idle", Busy, 0);
      check("err_sticky", Error, 1);

      // Reset mid-WAIT
      n = 0;
      Run = 1'b1;
      while (!ReadEn && n < 50) begin tick(); n++; end
      PT = 128'h1234; Mode = 1'b1; ReadRy = 1'b1;
      start_q.push_back({1'b1, 128'h1234});
      tick();
      ReadRy = 1'b0;
      Run = 1'b0;
      repeat (6) tick();
      check("pre_rst_busy", Busy, 1);
      #2 Rst_n = 1'b0;
      #1;
      check("async_rst_outputs", {ReadEn, WriteEn, AesStart, AesMode, Busy, Error}, 0);
      check("async_rst_data", {Result, AesIn, BlkCount} == 0, 1);
      #2 Rst_n = 1'b1;
      blk_model = '0;
      tick();
      check("post_rst_idle", Busy, 0);

      // Run dropped while receiving
      Run = 1'b1;
      tick();
      check("rx_entered", ReadEn, 1);
      Run = 1'b0;
      tick();
      check("rx_abort", {ReadEn, Busy}, 0);

      repeat (3) tick();
      check("queues_drained", start_q.size() + tx_q.size() + blk_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
